// File: rtl/reg_wb_pkg.sv
// Shared widths and the write-back queue entry type.
package reg_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue storage: circular buffer with per-slot valid bits exposed for
// the scoreboard lookup in the parent.
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_entry_t [DEPTH-1:0]    entries_o,
  output logic [DEPTH-1:0]         valid_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o    = (cnt_q == CntW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rptr_q];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

  // Next-state: write at wptr, retire at rptr; pointers wrap as DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wptr_q]   = push_entry_i;
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // State registers; reset discards all pending entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: arbitrates load/ALU results into an
// in-order queue, drains it to the write port, and answers pending-write queries.
module reg_wb_ctrl
  import reg_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_stall,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] q_addr1,
  input  logic [REG_ADDR_W-1:0] q_addr2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic [$clog2(DEPTH):0] count
);

  logic                  full, empty;
  logic                  mem_acc, alu_acc, push;
  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;

  // Arbitration: load beats ALU; readies depend only on queue state and mem_valid.
  always_comb begin
    mem_ready  = !full;
    alu_ready  = !full && !mem_valid;
    mem_acc    = mem_valid && mem_ready;
    alu_acc    = alu_valid && alu_ready;
    push_entry = mem_acc ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
    // Writes to r0 are handshaken but dropped.
    push       = (mem_acc && (mem_rd != '0)) || (alu_acc && (alu_rd != '0));
  end

  // Write port shows the queue head; zeroed when nothing is pending.
  always_comb begin
    wr_en   = !empty && !wb_stall;
    wr_addr = empty ? '0 : head.rd;
    wr_data = empty ? '0 : head.data;
  end

  // Scoreboard: any valid entry (head included) targeting the queried register.
  always_comb begin
    q_busy1 = 1'b0;
    q_busy2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (entries[i].rd == q_addr1) && (q_addr1 != '0)) q_busy1 = 1'b1;
      if (valid[i] && (entries[i].rd == q_addr2) && (q_addr2 != '0)) q_busy2 = 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (wr_en),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (count),
    .entries_o    (entries),
    .valid_o      (valid)
  );

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, meaning write-back queue entries; the value SHALL be a power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU result write request.
REQ-005 alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 mem_valid  input  1  load-data write request.
REQ-009 mem_ready  output  1  load request accepted this cycle when high with mem_valid.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  32  load data.
REQ-012 wb_stall  input  1  register-file write port unavailable; hold queue head.
REQ-013 wr_en  output  1  register-file write enable.
REQ-014 wr_addr  output  5  register-file write address.
REQ-015 wr_data  output  32  register-file write data.
REQ-016 q_addr1, q_addr2  input  5 each  scoreboard query registers.
REQ-017 q_busy1, q_busy2  output  1 each  pending write exists to the queried register.
REQ-018 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 Queue SHALL hold {rd, data} entries in FIFO order; register-file writes SHALL occur in acceptance order.
REQ-020 At most one request SHALL be accepted per cycle; mem has fixed priority over alu.
REQ-021 mem_ready = !full; alu_ready = !full && !mem_valid; neither SHALL depend combinationally on wb_stall or pop.
REQ-022 Accepted request with rd = 0 SHALL complete the handshake and SHALL NOT be enqueued.
REQ-023 wr_en = !empty && !wb_stall; wr_addr/wr_data SHALL show the head entry, or 0 when empty.
REQ-024 Pop SHALL occur at a clock edge where wr_en = 1.
REQ-025 Latency: request accepted at edge N into an empty queue SHALL produce wr_en = 1 in cycle N+1 (absent stall).
REQ-026 Simultaneous push and pop SHALL leave count unchanged; full with pop in progress SHALL still deassert both readies.
REQ-027 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-028 q_busyN = 1 iff q_addrN != 0 and any valid entry (including the head being popped this cycle) has rd = q_addrN; same-cycle incoming requests SHALL NOT count.
REQ-029 Multiple pending entries to one register SHALL all be written, oldest first.

Reset
REQ-030 rst_n low SHALL immediately clear pointers, count and all valid bits; pending entries SHALL be discarded.
REQ-031 During and after reset: wr_en = 0, wr_addr = 0, wr_data = 0, q_busy1/2 = 0, count = 0, alu_ready = mem_ready = 1.
REQ-032 Reset deassertion SHALL be synchronised by the block's caller; the block SHALL accept requests in the first cycle after release.

Structure
REQ-033 Package reg_wb_pkg SHALL hold REG_ADDR_W = 5, DATA_W = 32 and the wb_entry_t typedef {rd, data}.
REQ-034 Storage and pointer logic SHALL be a sub-module wb_fifo; arbitration, r0 filter and scoreboard compare stay in reg_wb_ctrl.

Verification
REQ-035 alu_valid, rd=5, data=0x1234 at edge 1 -> wr_en=1, wr_addr=5, wr_data=0x1234 in cycle 2, count back to 0 after edge 2.
REQ-036 Both valid same cycle (mem rd=3 0xAA, alu rd=4 0xBB) -> mem accepted first, alu_ready=0; next cycle alu accepted; writes 3 then 4.
REQ-037 wb_stall=1, 5 alu requests with DEPTH=4 -> 4 accepted, alu_ready=0, count=4; release stall -> 4 writes in order, wrap-around exercised.
REQ-038 Request with rd=0 -> handshake completes, count unchanged, no wr_en; q_addr1=0 -> q_busy1=0.
REQ-039 Two pending writes to r7, q_addr1=7 -> q_busy1=1 until the second write pops, then 0.
REQ-040 rst_n low with count=3 mid-drain -> outputs zero immediately, count=0, no further writes after release.
